// File: rtl/load_store_unit.sv
// RV32I memory-access stage: byte-lane placement for stores, sign/zero extension for loads, req/gnt/rvalid data port.
// Latency: store 2 cycles, load 3 cycles minimum; upstream stalls on o_busy until the access completes or aborts.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [3:0]  i_mem_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_busy,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic [31:0] o_fault_addr
);

  localparam logic [3:0] MEM_LB = 4'd0, MEM_LH = 4'd1, MEM_LW = 4'd2, MEM_LBU = 4'd3,
                         MEM_LHU = 4'd4, MEM_SB = 4'd5, MEM_SH = 4'd6, MEM_SW = 4'd7;

  // Counter only ever needs to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;

  logic          fault;
  logic          is_store;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   byte_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          timed_out;

  assign o_busy    = (state != IDLE);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

  always_comb begin
    fault    = 1'b0;
    is_store = 1'b0;
    st_be    = 4'b1111;
    st_wdata = i_wdata;
    case (i_mem_op)
      MEM_LB, MEM_LBU: fault = 1'b0;
      MEM_LH, MEM_LHU: fault = i_addr[0];
      MEM_LW:          fault = |i_addr[1:0];
      MEM_SB: begin
        is_store = 1'b1;
        st_be    = 4'b0001 << i_addr[1:0];
        st_wdata = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        is_store = 1'b1;
        fault    = i_addr[0];
        st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_wdata[15:0]}};
      end
      MEM_SW: begin
        is_store = 1'b1;
        fault    = |i_addr[1:0];
      end
      default: fault = 1'b1;
    endcase
  end

  assign byte_word = i_dmem_rdata >> {addr_q[1:0], 3'b000};
  assign ld_byte   = byte_word[7:0];
  assign ld_half   = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    ld_data = i_dmem_rdata;
    case (op_q)
      MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data = {24'd0, ld_byte};
      MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data = {16'd0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      cnt          <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_wb_valid   <= 1'b0;
      o_wb_rd      <= '0;
      o_wb_data    <= '0;
      o_misalign   <= 1'b0;
      o_bus_err    <= 1'b0;
      o_fault_addr <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (fault) begin
              o_misalign   <= 1'b1;
              o_fault_addr <= i_addr;
            end else begin
              op_q         <= i_mem_op;
              addr_q       <= i_addr;
              rd_q         <= i_rd;
              cnt          <= '0;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= is_store;
              o_dmem_addr  <= {i_addr[31:2], 2'b00};
              o_dmem_be    <= st_be;
              o_dmem_wdata <= st_wdata;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          // A grant in the limit cycle still wins over the timeout.
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            cnt        <= '0;
            state      <= o_dmem_we ? IDLE : WAIT;
          end else if (timed_out) begin
            o_dmem_req   <= 1'b0;
            o_bus_err    <= 1'b1;
            o_fault_addr <= addr_q;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_rd    <= rd_q;
            o_wb_data  <= ld_data;
            state      <= IDLE;
          end else if (timed_out) begin
            o_bus_err    <= 1'b1;
            o_fault_addr <= addr_q;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle timeout; inputs change 1ns after the rising edge, outputs are read there too.
module tb_load_store_unit;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [3:0]  i_mem_op;
  logic [31:0] i_addr, i_wdata, i_dmem_rdata;
  logic [4:0]  i_rd;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic        o_busy, o_dmem_req, o_dmem_we, o_wb_valid, o_misalign, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data, o_fault_addr;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_wb_rd;

  int n_cmp = 0;
  int n_fail = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_op(i_mem_op),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .o_busy(o_busy),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err), .o_fault_addr(o_fault_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [159:0] all_outs();
    return {o_busy, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
            o_wb_valid, o_wb_rd, o_wb_data, o_misalign, o_bus_err, o_fault_addr, 5'd0};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 0; i_mem_op = 0; i_addr = 0; i_wdata = 0; i_rd = 0;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    tick(); tick();
    n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    i_rst = 1'b0;
    tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b want 0", o_busy); end
  endtask

  task automatic test_sb();
    i_valid = 1; i_mem_op = 4'd5; i_addr = 32'h1003; i_wdata = 32'h0000_00A5;
    tick();
    i_valid = 0; i_dmem_gnt = 1;
    n_cmp++; if ({o_busy, o_dmem_req, o_dmem_we} !== 3'b111) begin n_fail++; $display("FAIL sb_req: busy/req/we %b want 111", {o_busy, o_dmem_req, o_dmem_we}); end
    n_cmp++; if (o_dmem_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", o_dmem_addr); end
    n_cmp++; if (o_dmem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", o_dmem_be); end
    n_cmp++; if (o_dmem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_dmem_wdata); end
    tick();
    i_dmem_gnt = 0;
    n_cmp++; if ({o_busy, o_dmem_req, o_wb_valid} !== 3'b000) begin n_fail++; $display("FAIL sb_done: busy/req/wb %b want 000", {o_busy, o_dmem_req, o_wb_valid}); end
    tick();
    n_cmp++; if (o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL sb_nowb: got %b want 0", o_wb_valid); end
  endtask

  task automatic run_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    i_valid = 1; i_mem_op = op; i_addr = addr; i_rd = rd;
    tick();
    i_valid = 0; i_dmem_gnt = 1;
    n_cmp++; if ({o_dmem_req, o_dmem_we, o_dmem_be} !== 6'b10_1111) begin n_fail++; $display("FAIL %s_req: req/we/be %b want 101111", nm, {o_dmem_req, o_dmem_we, o_dmem_be}); end
    tick();
    i_dmem_gnt = 0; i_dmem_rvalid = 1; i_dmem_rdata = rdata;
    n_cmp++; if ({o_busy, o_dmem_req, o_wb_valid} !== 3'b100) begin n_fail++; $display("FAIL %s_wait: busy/req/wb %b want 100", nm, {o_busy, o_dmem_req, o_wb_valid}); end
    tick();
    i_dmem_rvalid = 0; i_dmem_rdata = 32'hDEAD_BEEF;
    n_cmp++; if ({o_wb_valid, o_busy} !== 2'b10) begin n_fail++; $display("FAIL %s_wbv: wb/busy %b want 10", nm, {o_wb_valid, o_busy}); end
    n_cmp++; if (o_wb_data !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, o_wb_data, exp); end
    n_cmp++; if (o_wb_rd !== rd) begin n_fail++; $display("FAIL %s_rd: got %0d want %0d", nm, o_wb_rd, rd); end
    tick();
    n_cmp++; if (o_wb_valid !== 1'b0 || o_wb_data !== exp) begin n_fail++; $display("FAIL %s_hold: wb %b data %h want 0 %h", nm, o_wb_valid, o_wb_data, exp); end
  endtask

  task automatic test_loads();
    run_load("lb",  4'd0, 32'h2002, 5'd3,  32'h0080_FF11, 32'hFFFF_FF80);
    run_load("lbu", 4'd3, 32'h2002, 5'd4,  32'h0080_FF11, 32'h0000_0080);
    run_load("lhu", 4'd4, 32'h2002, 5'd5,  32'hBEEF_1234, 32'h0000_BEEF);
    run_load("lh",  4'd1, 32'h2002, 5'd6,  32'hBEEF_1234, 32'hFFFF_BEEF);
    run_load("lw",  4'd2, 32'h2000, 5'd31, 32'hBEEF_1234, 32'hBEEF_1234);
  endtask

  task automatic run_fault(input string nm, input logic [3:0] op, input logic [31:0] addr);
    i_valid = 1; i_mem_op = op; i_addr = addr;
    tick();
    i_valid = 0;
    n_cmp++; if ({o_misalign, o_dmem_req, o_busy} !== 3'b100) begin n_fail++; $display("FAIL %s_pulse: mis/req/busy %b want 100", nm, {o_misalign, o_dmem_req, o_busy}); end
    n_cmp++; if (o_fault_addr !== addr) begin n_fail++; $display("FAIL %s_faddr: got %h want %h", nm, o_fault_addr, addr); end
    tick();
    n_cmp++; if ({o_misalign, o_dmem_req} !== 2'b00) begin n_fail++; $display("FAIL %s_after: mis/req %b want 00", nm, {o_misalign, o_dmem_req}); end
  endtask

  task automatic test_misalign();
    run_fault("lw_mis", 4'd2, 32'h3001);
    run_fault("illegal", 4'd9, 32'h4000);
    run_fault("sh_mis", 4'd6, 32'h4003);
  endtask

  task automatic test_timeout();
    int reqs = 0, errs = 0;
    logic [31:0] faddr = '0;
    i_valid = 1; i_mem_op = 4'd2; i_addr = 32'h5000; i_rd = 5'd7;
    tick();
    i_valid = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_dmem_req) reqs++;
      if (o_bus_err) begin errs++; faddr = o_fault_addr; end
      tick();
    end
    n_cmp++; if (reqs != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", reqs); end
    n_cmp++; if (errs != 1) begin n_fail++; $display("FAIL to_bus_err: got %0d pulses want 1", errs); end
    n_cmp++; if (faddr !== 32'h5000) begin n_fail++; $display("FAIL to_faddr: got %h want 00005000", faddr); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", o_busy); end
    i_dmem_gnt = 1; i_dmem_rvalid = 1;
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_dmem_req || o_wb_valid || o_busy || o_bus_err) errs++;
    end
    i_dmem_gnt = 0; i_dmem_rvalid = 0;
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL to_stray: got %0d responsive cycles want 0", errs); end
  endtask

  task automatic test_gnt_at_limit();
    i_valid = 1; i_mem_op = 4'd2; i_addr = 32'h6000; i_rd = 5'd9;
    tick();
    i_valid = 0;
    tick(); tick(); tick();
    i_dmem_gnt = 1;
    tick();
    i_dmem_gnt = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h1357_9BDF;
    n_cmp++; if ({o_busy, o_dmem_req, o_bus_err} !== 3'b100) begin n_fail++; $display("FAIL lim_gnt: busy/req/err %b want 100", {o_busy, o_dmem_req, o_bus_err}); end
    tick();
    i_dmem_rvalid = 0;
    n_cmp++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h1357_9BDF) begin n_fail++; $display("FAIL lim_wb: wb %b data %h want 1 13579bdf", o_wb_valid, o_wb_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    i_valid = 1; i_mem_op = 4'd2; i_addr = 32'h7000; i_rd = 5'd11;
    tick();
    i_valid = 0; i_dmem_gnt = 1;
    tick();
    i_dmem_gnt = 0;
    i_rst = 1'b1;
    #1;
    n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL rst_mid_outs: got %h want 0", all_outs()); end
    tick();
    i_rst = 1'b0;
    tick(); tick();
    i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
    tick();
    i_dmem_rvalid = 0;
    n_cmp++; if ({o_wb_valid, o_busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_rvalid: wb/busy %b want 00", {o_wb_valid, o_busy}); end
    tick();
    n_cmp++; if (o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_late: got %b want 0", o_wb_valid); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_loads();
    test_misalign();
    test_timeout();
    test_gnt_at_limit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
